// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : MEM-stage load/store sequencer for the req/addr_ok/data_ok data bus
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_sign_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [ADDR_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [ADDR_W-1:0] rdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [ADDR_W-1:0] data_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]        r_state;
    logic              r_cancel;
    logic              r_sign;
    logic              w_misalign;
    logic              w_start;
    logic [3:0]        w_wstrb;
    logic [ADDR_W-1:0] w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [ADDR_W-1:0] w_loadData;

    // Size 3 shares the word alignment rule.
    assign w_misalign = ((mem_size_i == 2'd1) & mem_addr_i[0])
                      | (mem_size_i[1] & (|mem_addr_i[1:0]));
    assign w_start    = mem_en_i & ~w_misalign & ~flush_i;
    assign stall_o    = w_start & (r_state != c_DONE);
    assign adel_o     = mem_en_i & w_misalign & ~mem_wr_i;
    assign ades_o     = mem_en_i & w_misalign & mem_wr_i;
    assign data_req   = (r_state == c_ADDR);

    // Big-endian lane order: offset 0 lives in bits [31:24].
    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = mem_wdata_i;
        case (mem_size_i)
            2'd0: begin
                w_wdata = {(ADDR_W/8){mem_wdata_i[7:0]}};
                if (mem_wr_i) w_wstrb = 4'b1000 >> mem_addr_i[1:0];
            end
            2'd1: begin
                w_wdata = {(ADDR_W/16){mem_wdata_i[15:0]}};
                if (mem_wr_i) w_wstrb = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                if (mem_wr_i) w_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (data_addr[1:0])
            2'd0:    w_byte = data_rdata[31:24];
            2'd1:    w_byte = data_rdata[23:16];
            2'd2:    w_byte = data_rdata[15:8];
            default: w_byte = data_rdata[7:0];
        endcase
        w_half = data_addr[1] ? data_rdata[15:0] : data_rdata[31:16];
        case (data_size)
            2'd0:    w_loadData = {{(ADDR_W-8){r_sign & w_byte[7]}}, w_byte};
            2'd1:    w_loadData = {{(ADDR_W-16){r_sign & w_half[15]}}, w_half};
            default: w_loadData = data_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cancel   <= 1'b0;
            r_sign     <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= '0;
            data_wstrb <= 4'b0000;
            data_wdata <= '0;
            rdata_o    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cancel <= 1'b0;
                    if (w_start) begin
                        r_state    <= c_ADDR;
                        r_sign     <= mem_sign_i;
                        data_wr    <= mem_wr_i;
                        data_size  <= mem_size_i;
                        data_addr  <= mem_addr_i;
                        data_wstrb <= w_wstrb;
                        data_wdata <= w_wdata;
                    end
                end
                c_ADDR: begin
                    if (flush_i) r_cancel <= 1'b1;
                    if (data_addr_ok) r_state <= c_DATA;
                end
                c_DATA: begin
                    // A flush coinciding with data_ok still discards the result.
                    if (data_data_ok) begin
                        if (r_cancel | flush_i) begin
                            r_state  <= c_IDLE;
                            r_cancel <= 1'b0;
                        end else begin
                            if (!data_wr) rdata_o <= w_loadData;
                            r_state <= c_DONE;
                        end
                    end else if (flush_i) begin
                        r_cancel <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Brief    : Randomized self-checking bench for dmem_access_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en_i, mem_wr_i, mem_sign_i, flush_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        stall_o, adel_o, ades_o;
    logic [31:0] rdata_o;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    int          nTests = 0;
    int          nFail  = 0;
    logic [31:0] lastRdata = 32'h0;

    dmem_access_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_en_i(mem_en_i), .mem_wr_i(mem_wr_i), .mem_size_i(mem_size_i),
        .mem_sign_i(mem_sign_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .stall_o(stall_o), .rdata_o(rdata_o),
        .adel_o(adel_o), .ades_o(ades_o),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nBytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] expStrb(input bit wr, input logic [1:0] size, input logic [31:0] addr);
        int nb  = nBytes(size);
        int off = int'(addr[1:0]);
        if (!wr) return 4'b0000;
        return 4'(((1 << nb) - 1) << (4 - nb - off));
    endfunction

    function automatic logic [31:0] expWdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return {24'h0, wd[7:0]} * 32'h01010101;
        if (size == 2'd1) return {16'h0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] expLoad(input logic [1:0] size, input bit sgn,
                                            input logic [31:0] addr, input logic [31:0] rd);
        int      nb    = nBytes(size);
        int      shift = (4 - nb - int'(addr[1:0])) * 8;
        longint  mask  = (64'd1 << (8 * nb)) - 1;
        longint  val   = (longint'(rd) >> shift) & mask;
        if (sgn && ((val >> (8 * nb - 1)) & 1) == 1) val = val | ~mask;
        return val[31:0];
    endfunction

    // One full access with the bench acting as bus slave; returns after the DONE cycle.
    task automatic doAccess(input bit wr, input logic [1:0] size, input bit sgn,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                            input int aDly, input int dDly, input bit okTogether);
        int  phase = 0;
        int  reqCycles = 0;
        int  dataWait = 0;
        bit  done = 0;
        bit  mis = (int'(addr[1:0]) % nBytes(size)) != 0;
        @(posedge clk); #1;
        flush_i = 0; data_addr_ok = 0; data_data_ok = 0;
        mem_en_i = 1; mem_wr_i = wr; mem_size_i = size; mem_sign_i = sgn;
        mem_addr_i = addr; mem_wdata_i = wd;
        #1;
        checkVal("adel", {31'h0, adel_o}, {31'h0, mis & ~wr});
        checkVal("ades", {31'h0, ades_o}, {31'h0, mis & wr});
        checkVal("rdataHold", rdata_o, lastRdata);
        checkVal("idleReq", {31'h0, data_req}, 32'h0);
        if (mis) begin
            checkVal("misStall", {31'h0, stall_o}, 32'h0);
            @(posedge clk); #1;
            checkVal("misReq", {31'h0, data_req}, 32'h0);
            mem_en_i = 0;
            return;
        end
        checkVal("acceptStall", {31'h0, stall_o}, 32'h1);
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(posedge clk); #1;
            data_addr_ok = 0; data_data_ok = 0;
            if (phase == 0) begin
                checkVal("addrStall", {31'h0, stall_o}, 32'h1);
                checkVal("addrReq", {31'h0, data_req}, 32'h1);
                if (data_req) begin
                    reqCycles++;
                    checkVal("busAddr", data_addr, addr);
                    checkVal("busWr", {31'h0, data_wr}, {31'h0, wr});
                    checkVal("busSize", {30'h0, data_size}, {30'h0, size});
                    checkVal("busStrb", {28'h0, data_wstrb}, {28'h0, expStrb(wr, size, addr)});
                    if (wr) checkVal("busWdata", data_wdata, expWdata(size, wd));
                    if (reqCycles == aDly + 1) begin
                        data_addr_ok = 1;
                        data_data_ok = okTogether;
                        data_rdata   = 32'hDEADBEEF;
                        phase = 1;
                    end
                end
            end else if (phase == 1) begin
                checkVal("dataStall", {31'h0, stall_o}, 32'h1);
                checkVal("dataReq", {31'h0, data_req}, 32'h0);
                if (dataWait == dDly) begin
                    data_data_ok = 1;
                    data_rdata   = rd;
                    phase = 2;
                end else begin
                    dataWait++;
                end
            end else begin
                if (!wr) lastRdata = expLoad(size, sgn, addr, rd);
                checkVal("doneStall", {31'h0, stall_o}, 32'h0);
                checkVal("doneRdata", rdata_o, lastRdata);
                done = 1;
            end
        end
        if (!done) checkVal("timeout", 32'h1, 32'h0);
        data_addr_ok = 0; data_data_ok = 0;
    endtask

    // Flush during ADDR (inData=0) or alongside data_ok in DATA (inData=1); the caller's
    // next doAccess observes the discarded result and the late acceptance.
    task automatic flushAccess(input bit inData);
        @(posedge clk); #1;
        flush_i = 0; data_addr_ok = 0; data_data_ok = 0;
        mem_en_i = 1; mem_wr_i = 0; mem_size_i = 2'd2; mem_sign_i = 0;
        mem_addr_i = 32'h5000; mem_wdata_i = 32'h0;
        @(posedge clk); #1;
        checkVal("flReq", {31'h0, data_req}, 32'h1);
        if (!inData) begin
            flush_i = 1; #1;
            checkVal("flStall", {31'h0, stall_o}, 32'h0);
            @(posedge clk); #1;
            flush_i = 0; mem_addr_i = 32'h5100; mem_size_i = 2'd1; mem_sign_i = 1;
            #1;
            checkVal("flNewStall", {31'h0, stall_o}, 32'h1);
            checkVal("flOldAddr", data_addr, 32'h5000);
        end
        data_addr_ok = 1;
        @(posedge clk); #1;
        data_addr_ok = 0;
        checkVal("flDataReq", {31'h0, data_req}, 32'h0);
        data_data_ok = 1; data_rdata = 32'h12345678;
        if (inData) begin
            flush_i = 1; #1;
            checkVal("flDataStall", {31'h0, stall_o}, 32'h0);
        end
    endtask

    initial begin
        rst = 1; mem_en_i = 0; mem_wr_i = 0; mem_size_i = 0; mem_sign_i = 0;
        mem_addr_i = 0; mem_wdata_i = 0; flush_i = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        #12;
        checkVal("rstReq", {31'h0, data_req}, 32'h0);
        checkVal("rstAddr", data_addr, 32'h0);
        checkVal("rstRdata", rdata_o, 32'h0);
        checkVal("rstStrb", {28'h0, data_wstrb}, 32'h0);
        rst = 0;

        doAccess(1, 2'd0, 0, 32'h1003, 32'h000000A5, 32'h0, 0, 0, 0);
        doAccess(0, 2'd1, 1, 32'h2000, 32'h0, 32'h80017FFF, 0, 0, 0);
        doAccess(0, 2'd1, 0, 32'h2002, 32'h0, 32'h80017FFF, 0, 0, 0);
        doAccess(0, 2'd2, 0, 32'h3002, 32'h0, 32'h0, 0, 0, 0);
        doAccess(1, 2'd1, 0, 32'h3001, 32'h1234, 32'h0, 0, 0, 0);
        doAccess(1, 2'd1, 0, 32'h3002, 32'h0000BEEF, 32'h0, 4, 3, 1);

        // Flush while idle: nothing starts.
        @(posedge clk); #1;
        mem_en_i = 1; mem_wr_i = 0; mem_size_i = 2'd2; mem_addr_i = 32'h4000; flush_i = 1;
        #1;
        checkVal("idleFlushStall", {31'h0, stall_o}, 32'h0);
        @(posedge clk); #1;
        checkVal("idleFlushReq", {31'h0, data_req}, 32'h0);
        flush_i = 0; mem_en_i = 0;

        flushAccess(0);
        doAccess(0, 2'd1, 1, 32'h5100, 32'h0, 32'h0000F00D, 1, 1, 0);
        flushAccess(1);
        doAccess(0, 2'd0, 1, 32'h5101, 32'h0, 32'h00A10000, 0, 2, 1);

        // Asynchronous reset while waiting in DATA.
        @(posedge clk); #1;
        mem_en_i = 1; mem_wr_i = 0; mem_size_i = 2'd2; mem_sign_i = 0; mem_addr_i = 32'h7000;
        @(posedge clk); #1;
        data_addr_ok = 1;
        @(posedge clk); #1;
        data_addr_ok = 0;
        rst = 1; mem_en_i = 0; #1;
        checkVal("arstReq", {31'h0, data_req}, 32'h0);
        checkVal("arstAddr", data_addr, 32'h0);
        checkVal("arstRdata", rdata_o, 32'h0);
        checkVal("arstWdata", data_wdata, 32'h0);
        checkVal("arstStall", {31'h0, stall_o}, 32'h0);
        lastRdata = 32'h0;
        #1 rst = 0; data_data_ok = 1; data_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        data_data_ok = 0;
        checkVal("lateOkRdata", rdata_o, 32'h0);
        checkVal("lateOkReq", {31'h0, data_req}, 32'h0);

        for (int i = 0; i < 60; i++) begin
            int dd = int'($urandom_range(0, 3));
            doAccess(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 3)), dd, (dd > 0) && ($urandom_range(0, 1) == 1));
        end
        @(posedge clk); #1;
        mem_en_i = 0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences MEM-stage loads and stores onto the SRAM-like data bus using the `req`/`addr_ok`/`data_ok` handshake.
- Generates the byte-lane write strobe and replicates store data across lanes.
- Extracts and sign- or zero-extends load data.
- Detects misaligned accesses and stalls the pipeline until the bus transaction completes.
- Sits between the MEM stage / hazard unit and the CPU's data-side bus interface.

Parameters:
- ADDR_W, 32, width of address and data buses.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- mem_en_i  in  1  MEM stage holds a load/store; held stable while stall_o=1
- mem_wr_i  in  1  1=store, 0=load
- mem_size_i  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- mem_sign_i  in  1  1=sign-extend load result
- mem_addr_i  in  32  effective address
- mem_wdata_i  in  32  store data, right-aligned
- flush_i  in  1  exception/flush; cancels the current access
- stall_o  out  1  freeze the pipeline
- rdata_o  out  32  extended load result, valid in DONE
- adel_o  out  1  load address error (combinational)
- ades_o  out  1  store address error (combinational)
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size, same encoding as mem_size_i
- data_addr  out  32  bus address, unmasked
- data_wstrb  out  4  byte write strobe
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase complete
- data_rdata  in  32  read data

Behaviour:
- Reset (async): state=IDLE, cancel=0. data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata, rdata_o are all 0. Reset mid-transaction drops data_req immediately; any late data_ok is ignored.
- Misalign:
  - Half with addr[0]=1, or word with addr[1:0]!=0.
  - Raises adel_o (load) or ades_o (store) while mem_en_i=1.
  - No bus request is issued and stall_o=0.
- Lane mapping:
  - Addr 00 is byte lane [31:24]; 11 is lane [7:0].
  - Byte wstrb: 00→1000, 01→0100, 10→0010, 11→0001.
  - Half wstrb: 00→1100, 10→0011.
  - Word wstrb: 1111. Loads use wstrb=0000.
- Store data: byte is replicated ×4; half is replicated ×2.
- Load extraction uses the same lane mapping, then sign-extends if mem_sign_i=1, else zero-extends.
- FSM: IDLE → ADDR → DATA → DONE → IDLE.
  - IDLE: if mem_en_i & ~misalign & ~flush_i, register all bus fields and go to ADDR.
  - ADDR: data_req=1, with fields held stable until data_addr_ok. On the addr_ok cycle, go to DATA; data_req=0 from the next cycle.
  - DATA: wait for data_data_ok. On data_ok, register the extracted rdata_o (loads only) and go to DONE, or go to IDLE if cancel=1.
  - DONE: one cycle, then IDLE. rdata_o holds until the next completed load.
- stall_o = mem_en_i & ~misalign & ~flush_i & (state≠DONE). The pipeline advances at the end of the DONE cycle.
- Minimum latency with addr_ok and data_ok each in their first possible cycle: accept in cycle 0, req in cycle 1, data_ok in cycle 2, DONE in cycle 3. stall_o is high in cycles 0–2.
- Flush:
  - In IDLE, no access starts.
  - In ADDR or DATA, the request cannot be withdrawn. cancel is set, the bus handshake completes, and the result is discarded: no DONE and rdata_o unchanged. cancel clears on return to IDLE.
  - A new request arriving while cancel=1 stalls until the FSM reaches IDLE.
- flush_i and data_ok in the same DATA cycle: the transaction is treated as cancelled.
- addr_ok and data_ok asserted together in ADDR: data_ok is ignored; data_ok must arrive in DATA.

Test Plan:
- Store byte 0xA5 at 0x1003, addr_ok/data_ok at earliest → data_wstrb=0001, data_wdata=0xA5A5A5A5, data_size=0, stall_o high 3 cycles then low 1.
- Load half signed at 0x2000, data_rdata=0x8001_7FFF → rdata_o=0xFFFF8001. Repeat at 0x2002 unsigned → 0x00007FFF.
- Load word at 0x3002 → adel_o=1, data_req never asserts, stall_o=0. Store half at 0x3001 → ades_o=1.
- addr_ok delayed 4 cycles, data_ok delayed 3 → data_req high 5 cycles with fields stable, stall_o high until DONE.
- flush_i in ADDR, then new load issued → old handshake completes, rdata_o unchanged, new request accepted only after IDLE.
- rst pulsed while in DATA → all outputs 0 asynchronously; subsequent data_ok ignored.
